ddr3_traffic_gen: RTL and testbench
===================================

DDR3_TRAFFIC_GEN -- requirements
Module: ddr3_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning width of ADDR.
REQ-002 SHALL have parameter BA_W, default 3, meaning width of BA.
REQ-003 SHALL have parameter DATA_W, default 64, meaning width of WR_DATA/RD_DATA, a multiple of 8 and at least 32.
REQ-004 SHALL have parameter START_ADDR, default 32765, meaning first address issued.
REQ-005 SHALL have parameter NUM_XFER, default 3, range 1..2**ADDR_W, meaning transfers per pass.
REQ-006 SHALL have parameter BURST_WORDS, default 16, range 1..256, meaning data words per transfer.
REQ-007 SHALL have parameter BANK_ILV, default 0, meaning 1 = rotate BA per transfer.
REQ-008 SHALL have parameter SEED, default 0, meaning data pattern base, DATA_W wide.
REQ-009 SHALL have these ports, in this order (name, direction, width, meaning):
- cpu_clk, in, 1, sole clock; all logic is sampled on the rising edge.
- RESET_N, in, 1, asynchronous active-low reset.
- START, in, 1, begin a pass; sampled only in IDLE.
- MODE, in, 2, pass type sampled with START: 0 write-only, 1 write then read-compare, 2 read-compare, 3 reserved (treated as 0).
- CMD_RDY, in, 1, controller accepts command this cycle.
- ADDR_VALID, out, 1, command request.
- ADDR, out, ADDR_W, command address.
- BA, out, BA_W, command bank address.
- CMD, out, 1, 1 = write, 0 = read.
- WR_DATA_VALID, in, 1, controller consumes WR_DATA this cycle.
- WR_DATA, out, DATA_W, current write word.
- RD_DATA_VALID, in, 1, RD_DATA is valid this cycle.
- RD_DATA, in, DATA_W, read word.
- BUSY, out, 1, pass in progress.
- DONE, out, 1, pass complete; held until the next accepted START.
- ERR_COUNT, out, 16, number of read mismatches, saturating.
- ERR_ADDR, out, ADDR_W, ADDR of the first mismatch.

Function
REQ-010 SHALL implement the states IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA and FINISH.
REQ-011 IDLE + START: SHALL clear the transfer counter t, word counter w, ERR_COUNT and DONE.
- The next state SHALL be RD_CMD if MODE=2, otherwise WR_CMD.
REQ-012 In WR_CMD/RD_CMD, SHALL assert ADDR_VALID with CMD set to 1 or 0 respectively.
- ADDR, BA and CMD SHALL stay stable until a cycle with CMD_RDY=1, which accepts the command.
- On acceptance, the next cycle SHALL move to WR_DATA/RD_DATA and deassert ADDR_VALID.
REQ-013 Address generation SHALL be as follows.
- BANK_ILV=0: ADDR = (START_ADDR + t) mod 2**ADDR_W, BA = 0.
- BANK_ILV=1: BA = t mod 2**BA_W and ADDR = (START_ADDR + (t >> BA_W)) mod 2**ADDR_W.
REQ-014 The data word for index (t, w) SHALL be D = SEED + t*BURST_WORDS + w.
- Arithmetic SHALL be modulo 2**DATA_W.
- The same D SHALL be used for writes and for the expected read value.
REQ-015 In WR_DATA, WR_DATA SHALL equal D(t, w).
- Each cycle with WR_DATA_VALID=1 SHALL increment w, and WR_DATA SHALL update on the next edge.
- WR_DATA_VALID outside WR_DATA SHALL be ignored.
REQ-016 In RD_DATA, each cycle with RD_DATA_VALID=1 SHALL compare RD_DATA against D(t, w) and then increment w.
- On a mismatch, ERR_COUNT SHALL increment, saturating at 16'hFFFF.
- On the first mismatch of a pass, ERR_ADDR SHALL capture the current ADDR.
- RD_DATA_VALID outside RD_DATA SHALL be ignored.
REQ-017 When the last word of a transfer (w = BURST_WORDS-1) is consumed, w SHALL clear and t SHALL increment.
- The next state SHALL be the matching CMD state if t+1 < NUM_XFER, otherwise the end-of-phase state.
REQ-018 The end-of-phase state SHALL be chosen as follows.
- End of write phase: RD_CMD with t cleared if MODE=1, otherwise FINISH.
- End of read phase: FINISH.
REQ-019 FINISH SHALL set DONE, clear BUSY and return to IDLE after one cycle.
REQ-020 BUSY SHALL be 1 in every state other than IDLE.
REQ-021 START SHALL be ignored while BUSY=1.
REQ-022 Counter widths SHALL be as follows.
- t: ceil(log2(NUM_XFER+1)) bits.
- w: ceil(log2(BURST_WORDS+1)) bits.
- No counter SHALL overflow within a pass.

Reset
REQ-023 RESET_N=0 SHALL asynchronously force IDLE.
- ADDR_VALID=0, CMD=0, ADDR=0, BA=0, WR_DATA=0, BUSY=0, DONE=0, ERR_COUNT=0, ERR_ADDR=0, t=0, w=0.
REQ-024 Reset asserted mid-pass SHALL abandon the pass with no further command issued.
- After release, the block SHALL wait in IDLE for START.

Verification
REQ-025 Defaults, MODE=0, START pulse, CMD_RDY=1 and WR_DATA_VALID=1 continuously:
- Requires 3 write commands at ADDR 32765, 32766, 32767.
- Requires words 0..15, 16..31, 32..47.
- Requires DONE=1 and ERR_COUNT=0.
REQ-026 CMD_RDY held 0 for 5 cycles in WR_CMD:
- Requires ADDR_VALID, ADDR and CMD stable for all 5 cycles.
- Requires acceptance on the first CMD_RDY=1 cycle.
REQ-027 MODE=1 with a loopback model returning the written data:
- Requires 3 writes followed by 3 reads at the same addresses.
- Requires ERR_COUNT=0.
REQ-028 MODE=2 with the model corrupting word 5 of transfer 1:
- Requires ERR_COUNT=1 and ERR_ADDR=32766.
REQ-029 START_ADDR=32767, NUM_XFER=2:
- Requires the second ADDR to wrap to 0.
REQ-030 BANK_ILV=1, NUM_XFER=9:
- Requires BA sequence 0..7,0 and ADDR START_ADDR for the first 8 transfers, then START_ADDR+1.
REQ-031 RESET_N pulsed low during WR_DATA:
- Requires immediate ADDR_VALID=0, BUSY=0 and IDLE.
- Requires a subsequent START to restart from t=0.

Source files
------------

// File: rtl/ddr3_traffic_gen.sv
// DDR3 controller traffic generator: issues write/read bursts with an incrementing
// data pattern and counts read-back mismatches.
module ddr3_traffic_gen #(
    parameter int                ADDR_W      = 15,
    parameter int                BA_W        = 3,
    parameter int                DATA_W      = 64,
    parameter int                START_ADDR  = 32765,
    parameter int                NUM_XFER    = 3,
    parameter int                BURST_WORDS = 16,
    parameter int                BANK_ILV    = 0,
    parameter logic [DATA_W-1:0] SEED        = '0
) (
    input  logic              cpu_clk,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic              CMD_RDY,
    output logic              ADDR_VALID,
    output logic [ADDR_W-1:0] ADDR,
    output logic [BA_W-1:0]   BA,
    output logic              CMD,
    input  logic              WR_DATA_VALID,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic              RD_DATA_VALID,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       ERR_COUNT,
    output logic [ADDR_W-1:0] ERR_ADDR
);

    localparam int TW = $clog2(NUM_XFER + 1);
    localparam int WW = $clog2(BURST_WORDS + 1);
    localparam logic [TW-1:0]     LAST_T    = TW'(NUM_XFER - 1);
    localparam logic [WW-1:0]     LAST_W    = WW'(BURST_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA, S_FINISH
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   t;
    logic [WW-1:0]   w;
    logic            wr_then_rd;
    logic            pass_start, take, mismatch;
    logic            xfer_done, rd_reload;

    assign ADDR_VALID = (state == S_WR_CMD) || (state == S_RD_CMD);
    assign BUSY       = (state != S_IDLE);
    assign xfer_done  = take && (w == LAST_W);
    assign rd_reload  = xfer_done && (state == S_WR_DATA) && (t == LAST_T) && wr_then_rd;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pass_start = 1'b0;
        take       = 1'b0;
        mismatch   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    pass_start = 1'b1;
                    state_next = (MODE == 2'd2) ? S_RD_CMD : S_WR_CMD;
                end
            end
            S_WR_CMD: if (CMD_RDY) state_next = S_WR_DATA;
            S_RD_CMD: if (CMD_RDY) state_next = S_RD_DATA;
            S_WR_DATA: begin
                if (WR_DATA_VALID) begin
                    take = 1'b1;
                    if (w == LAST_W) begin
                        if (t != LAST_T)  state_next = S_WR_CMD;
                        else if (wr_then_rd) state_next = S_RD_CMD;
                        else              state_next = S_FINISH;
                    end
                end
            end
            S_RD_DATA: begin
                if (RD_DATA_VALID) begin
                    take     = 1'b1;
                    mismatch = (RD_DATA != WR_DATA);
                    if (w == LAST_W) state_next = (t != LAST_T) ? S_RD_CMD : S_FINISH;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // WR_DATA doubles as the running pattern D(t, w), so it is also the read reference.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            t          <= '0;
            w          <= '0;
            wr_then_rd <= 1'b0;
            ADDR       <= '0;
            BA         <= '0;
            CMD        <= 1'b0;
            WR_DATA    <= '0;
            DONE       <= 1'b0;
            ERR_COUNT  <= '0;
            ERR_ADDR   <= '0;
        end else begin
            state <= state_next;
            if (pass_start) begin
                t          <= '0;
                w          <= '0;
                ERR_COUNT  <= '0;
                DONE       <= 1'b0;
                wr_then_rd <= (MODE == 2'd1);
                ADDR       <= ADDR_INIT;
                BA         <= '0;
                CMD        <= (MODE != 2'd2);
                WR_DATA    <= SEED;
            end else if (state == S_FINISH) begin
                DONE <= 1'b1;
            end
            if (take) begin
                WR_DATA <= WR_DATA + 1'b1;
                if (xfer_done) begin
                    w <= '0;
                    t <= t + 1'b1;
                    if (rd_reload) begin
                        t       <= '0;
                        ADDR    <= ADDR_INIT;
                        BA      <= '0;
                        CMD     <= 1'b0;
                        WR_DATA <= SEED;
                    end else if (BANK_ILV != 0) begin
                        BA <= BA + 1'b1;
                        if (&BA) ADDR <= ADDR + 1'b1;
                    end else begin
                        ADDR <= ADDR + 1'b1;
                    end
                end else begin
                    w <= w + 1'b1;
                end
            end
            if (mismatch) begin
                if (ERR_COUNT != 16'hFFFF) ERR_COUNT <= ERR_COUNT + 16'd1;
                if (ERR_COUNT == 16'd0)    ERR_ADDR  <= ADDR;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Scoreboard bench for ddr3_traffic_gen: a default instance for pass types, stalls and
// reset, plus a bank-interleaved instance for address/data wrap.
module tb_ddr3_traffic_gen;

    localparam int ADDR_W  = 15;
    localparam int BA_W    = 3;
    localparam int DATA_W  = 64;
    localparam int A_START = 32765;
    localparam int A_NX    = 3;
    localparam int A_BW    = 16;
    localparam int B_START = 32767;
    localparam int B_NX    = 9;
    localparam int B_BW    = 2;
    localparam logic [DATA_W-1:0] B_SEED = 64'hFFFF_FFFF_FFFF_FFFE;

    typedef struct packed {
        logic              cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              start, cmd_rdy, wr_valid, rd_valid;
    logic [1:0]        mode;
    logic [DATA_W-1:0] rd_data, wr_data;
    logic              addr_valid, cmd, busy, done;
    logic [ADDR_W-1:0] addr, err_addr;
    logic [BA_W-1:0]   ba;
    logic [15:0]       err_count;

    logic              b_start, b_cmd_rdy, b_wr_valid, b_rd_valid;
    logic [1:0]        b_mode;
    logic [DATA_W-1:0] b_rd_data, b_wr_data;
    logic              b_addr_valid, b_cmd, b_busy, b_done;
    logic [ADDR_W-1:0] b_addr, b_err_addr;
    logic [BA_W-1:0]   b_ba;
    logic [15:0]       b_err_count;

    ddr3_traffic_gen dut (
        .cpu_clk(clk), .RESET_N(rst_n), .START(start), .MODE(mode), .CMD_RDY(cmd_rdy),
        .ADDR_VALID(addr_valid), .ADDR(addr), .BA(ba), .CMD(cmd),
        .WR_DATA_VALID(wr_valid), .WR_DATA(wr_data),
        .RD_DATA_VALID(rd_valid), .RD_DATA(rd_data),
        .BUSY(busy), .DONE(done), .ERR_COUNT(err_count), .ERR_ADDR(err_addr)
    );

    ddr3_traffic_gen #(
        .START_ADDR(B_START), .NUM_XFER(B_NX), .BURST_WORDS(B_BW),
        .BANK_ILV(1), .SEED(B_SEED)
    ) dut_b (
        .cpu_clk(clk), .RESET_N(rst_n), .START(b_start), .MODE(b_mode), .CMD_RDY(b_cmd_rdy),
        .ADDR_VALID(b_addr_valid), .ADDR(b_addr), .BA(b_ba), .CMD(b_cmd),
        .WR_DATA_VALID(b_wr_valid), .WR_DATA(b_wr_data),
        .RD_DATA_VALID(b_rd_valid), .RD_DATA(b_rd_data),
        .BUSY(b_busy), .DONE(b_done), .ERR_COUNT(b_err_count), .ERR_ADDR(b_err_addr)
    );

    int vectors = 0;
    int miscompares = 0;
    cmd_t              cmd_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [DATA_W-1:0] mem[int];

    function automatic logic [ADDR_W-1:0] a_addr(input int t);
        return ADDR_W'((A_START + t) % (1 << ADDR_W));
    endfunction

    function automatic void push_pass(input logic [1:0] m);
        cmd_t c;
        if (m != 2'd2) begin
            for (int t = 0; t < A_NX; t++) begin
                c.cmd = 1'b1; c.ba = '0; c.addr = a_addr(t);
                cmd_q.push_back(c);
                for (int w = 0; w < A_BW; w++) data_q.push_back(DATA_W'(t * A_BW + w));
            end
        end
        if (m == 2'd1 || m == 2'd2) begin
            for (int t = 0; t < A_NX; t++) begin
                c.cmd = 1'b0; c.ba = '0; c.addr = a_addr(t);
                cmd_q.push_back(c);
            end
        end
    endfunction

    // Waits for a command, checks it against the scoreboard, optionally stalls it
    // (with ignored START/data-valid noise), then accepts it.
    task automatic do_cmd(input int stall, output bit ok, output int key);
        cmd_t e;
        int g = 0;
        ok = 1'b0;
        key = 0;
        while (addr_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        vectors++;
        if (addr_valid !== 1'b1 || cmd_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_wait: ADDR_VALID=%b queued=%0d, expected valid command", addr_valid, cmd_q.size());
            return;
        end
        e = cmd_q.pop_front();
        key = int'({e.ba, e.addr});
        vectors++;
        if ({cmd, ba, addr} !== e) begin
            miscompares++;
            $display("FAIL cmd_fields: cmd=%b ba=%0d addr=%0d, expected cmd=%b ba=%0d addr=%0d",
                     cmd, ba, addr, e.cmd, e.ba, e.addr);
        end
        for (int i = 0; i < stall; i++) begin
            cmd_rdy = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; start = 1'b1; mode = 2'd2;
            @(negedge clk);
            vectors++;
            if ({addr_valid, cmd, ba, addr} !== {1'b1, e}) begin
                miscompares++;
                $display("FAIL cmd_hold[%0d]: valid=%b cmd=%b addr=%0d, expected 1 %b %0d",
                         i, addr_valid, cmd, addr, e.cmd, e.addr);
            end
        end
        start = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        vectors++;
        if (addr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cmd_accept: ADDR_VALID=%b, expected 0", addr_valid);
        end
        ok = 1'b1;
    endtask

    task automatic do_burst(input bit is_wr, input int t, input int key, input bit gaps,
                            input int ct, input int cw);
        int n = 0;
        int guard = 0;
        bit v;
        logic [DATA_W-1:0] exp;
        while (n < A_BW && guard < 400) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (is_wr) begin
                wr_valid = v;
                if (v) begin
                    exp = data_q.pop_front();
                    vectors++;
                    if (wr_data !== exp) begin
                        miscompares++;
                        $display("FAIL wr_data t=%0d w=%0d: got %h, expected %h", t, n, wr_data, exp);
                    end
                    mem[key * 256 + n] = exp;
                    n++;
                end
            end else begin
                rd_valid = v;
                if (v) begin
                    rd_data = mem.exists(key * 256 + n) ? mem[key * 256 + n] : '0;
                    if (t == ct && n == cw) rd_data = rd_data ^ 64'd1;
                    n++;
                end else begin
                    rd_data = {$urandom, $urandom};
                end
            end
            guard++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        vectors++;
        if (n != A_BW) begin
            miscompares++;
            $display("FAIL burst_len: consumed %0d, expected %0d", n, A_BW);
        end
    endtask

    task automatic run_pass(input logic [1:0] m, input int stall, input bit gaps,
                            input int ct, input int cw, input logic [15:0] exp_err);
        int wt = 0, rt = 0, g = 0, key;
        bit ok = 1'b1;
        cmd_t c;
        push_pass(m);
        mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL pass_start: busy=%b done=%b, expected 1 0", busy, done);
        end
        while (cmd_q.size() > 0 && ok) begin
            c = cmd_q[0];
            do_cmd(stall, ok, key);
            if (ok) begin
                do_burst(c.cmd, c.cmd ? wt : rt, key, gaps, ct, cw);
                if (c.cmd) wt++; else rt++;
            end
        end
        while (done !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL pass_done: busy=%b done=%b, expected 0 1", busy, done);
        end
        vectors++;
        if (err_count !== exp_err) begin
            miscompares++;
            $display("FAIL err_count: got %0d, expected %0d", err_count, exp_err);
        end
        vectors++;
        if (cmd_q.size() != 0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d cmds %0d words left, expected 0 0", cmd_q.size(), data_q.size());
        end
        cmd_q.delete();
        data_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 0; mode = 0; cmd_rdy = 0; wr_valid = 0; rd_valid = 0; rd_data = '0;
        b_start = 0; b_mode = 0; b_cmd_rdy = 0; b_wr_valid = 0; b_rd_valid = 0; b_rd_data = '0;
        #12;
        vectors++;
        if ({addr_valid, cmd, ba, addr, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: valid=%b cmd=%b ba=%0d addr=%0d busy=%b done=%b, expected all 0",
                     addr_valid, cmd, ba, addr, busy, done);
        end
        vectors++;
        if ({wr_data, err_count, err_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: wr_data=%h err_count=%0d err_addr=%0d, expected 0",
                     wr_data, err_count, err_addr);
        end
        vectors++;
        if ({b_addr_valid, b_busy, b_done, b_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_b: valid=%b busy=%b done=%b wr_data=%h, expected 0",
                     b_addr_valid, b_busy, b_done, b_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_only;
        run_pass(2'd0, 0, 1'b0, -1, 0, 16'd0);
    endtask

    task automatic test_cmd_stall;
        run_pass(2'd0, 5, 1'b0, -1, 0, 16'd0);
    endtask

    task automatic test_write_read;
        mem.delete();
        run_pass(2'd1, 0, 1'b1, -1, 0, 16'd0);
    endtask

    task automatic test_read_corrupt;
        run_pass(2'd2, 0, 1'b0, 1, 5, 16'd1);
        vectors++;
        if (err_addr !== ADDR_W'(32766)) begin
            miscompares++;
            $display("FAIL err_addr: got %0d, expected 32766", err_addr);
        end
    endtask

    task automatic test_back_to_back;
        run_pass(2'd3, 1, 1'b1, -1, 0, 16'd0);
        run_pass(2'd2, 0, 1'b1, 0, 15, 16'd1);
        vectors++;
        if (err_addr !== a_addr(0)) begin
            miscompares++;
            $display("FAIL err_addr_recapture: got %0d, expected %0d", err_addr, a_addr(0));
        end
    endtask

    task automatic test_mid_reset;
        bit ok;
        int key;
        push_pass(2'd0);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_cmd(0, ok, key);
        wr_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({addr_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_ctrl: valid=%b busy=%b done=%b, expected 0 0 0", addr_valid, busy, done);
        end
        vectors++;
        if (wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_data: wr_data=%h, expected 0", wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({addr_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: valid=%b busy=%b, expected 0 0", i, addr_valid, busy);
            end
        end
        wr_valid = 1'b0;
        cmd_q.delete();
        data_q.delete();
        run_pass(2'd0, 0, 1'b0, -1, 0, 16'd0);
    endtask

    task automatic test_bank_ilv_wrap;
        int g;
        logic [DATA_W-1:0] exp;
        b_cmd_rdy = 1'b1; b_wr_valid = 1'b1; b_mode = 2'd0; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int t = 0; t < B_NX; t++) begin
            g = 0;
            while (b_addr_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
            vectors++;
            if ({b_addr_valid, b_cmd, b_ba, b_addr} !==
                {1'b1, 1'b1, BA_W'(t % 8), ADDR_W'((B_START + t / 8) % (1 << ADDR_W))}) begin
                miscompares++;
                $display("FAIL ilv_cmd t=%0d: valid=%b ba=%0d addr=%0d, expected 1 %0d %0d",
                         t, b_addr_valid, b_ba, b_addr, t % 8, (B_START + t / 8) % (1 << ADDR_W));
            end
            @(negedge clk);
            for (int w = 0; w < B_BW; w++) begin
                exp = B_SEED + DATA_W'(t * B_BW + w);
                vectors++;
                if (b_wr_data !== exp) begin
                    miscompares++;
                    $display("FAIL ilv_data t=%0d w=%0d: got %h, expected %h", t, w, b_wr_data, exp);
                end
                @(negedge clk);
            end
        end
        g = 0;
        while (b_done !== 1'b1 && g < 10) begin @(negedge clk); g++; end
        vectors++;
        if ({b_busy, b_done, b_err_count} !== {2'b01, 16'd0}) begin
            miscompares++;
            $display("FAIL ilv_done: busy=%b done=%b err=%0d, expected 0 1 0", b_busy, b_done, b_err_count);
        end
        b_cmd_rdy = 1'b0;
        b_wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_cmd_stall();
        test_write_read();
        test_read_corrupt();
        test_back_to_back();
        test_mid_reset();
        test_bank_ilv_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
